// File: rtl/hub75_scan_driver.sv
// HUB75 row-pair scan controller: reads the framebuffer by (addr, column), shifts
// pixels out with a generated panel clock, then latches the row and unblanks.
module hub75_scan_driver #(
  parameter int unsigned COLUMNS   = 64,
  parameter int unsigned ROWS_HALF = 16,
  parameter int unsigned ON_CYCLES = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   rgb0_in,
  input  logic [2:0]                   rgb1_in,
  output logic [$clog2(COLUMNS)-1:0]   column,
  output logic [$clog2(ROWS_HALF)-1:0] addr,
  output logic [2:0]                   hub_rgb0,
  output logic [2:0]                   hub_rgb1,
  output logic                         hub_clk,
  output logic                         hub_lat,
  output logic                         hub_oe_n,
  output logic [$clog2(ROWS_HALF)-1:0] hub_addr,
  output logic                         frame_start
);
  localparam int CW = $clog2(COLUMNS);
  localparam int AW = $clog2(ROWS_HALF);
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] S_LAST = SW'(2 * COLUMNS - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, UNBLANK} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] hub_addr_q, hub_addr_d;
  logic          shown_q, shown_d;
  logic [2:0]    rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic          clk_q, clk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      addr_q     <= '0;
      hub_addr_q <= '0;
      shown_q    <= 1'b0;
      rgb0_q     <= '0;
      rgb1_q     <= '0;
      clk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      addr_q     <= addr_d;
      hub_addr_q <= hub_addr_d;
      shown_q    <= shown_d;
      rgb0_q     <= rgb0_d;
      rgb1_q     <= rgb1_d;
      clk_q      <= clk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    addr_d     = addr_q;
    hub_addr_d = hub_addr_q;
    shown_d    = shown_q;
    rgb0_d     = rgb0_q;
    rgb1_d     = rgb1_q;
    clk_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHIFT;
          s_d     = '0;
        end
      end
      SHIFT: begin
        // Even half: present the pixel with clock low; odd half: raise the clock.
        if (!s_q[0]) begin
          rgb0_d = rgb0_in;
          rgb1_d = rgb1_in;
        end
        clk_d = s_q[0];
        s_d   = s_q + 1'b1;
        if (s_q == S_LAST) state_d = BLANK;
      end
      BLANK: state_d = LATCH;
      LATCH: begin
        hub_addr_d = addr_q;
        shown_d    = 1'b1;
        state_d    = UNBLANK;
      end
      UNBLANK: begin
        addr_d  = addr_q + 1'b1;
        s_d     = '0;
        state_d = en ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Nothing valid sits in the panel latches until the first LATCH, hence shown_q.
  assign hub_oe_n    = !((state_q == SHIFT) && shown_q && (32'(s_q) < ON_CYCLES));
  assign hub_lat     = (state_q == LATCH);
  assign frame_start = (state_q == SHIFT) && (s_q == '0) && (addr_q == '0);
  assign column      = s_q[SW-1:1];
  assign addr        = addr_q;
  assign hub_addr    = hub_addr_q;
  assign hub_rgb0    = rgb0_q;
  assign hub_rgb1    = rgb1_q;
  assign hub_clk     = clk_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench: three scan drivers (ON_CYCLES 40, 0, 128) share clk/rst/en,
// each reading its own framebuffer model {column[2:0]} / ~{column[2:0]}.
module tb_hub75_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] col_w   [3];
  logic [3:0] addr_w  [3];
  logic [3:0] haddr_w [3];
  logic [2:0] r0_w    [3];
  logic [2:0] r1_w    [3];
  logic [2:0] hr0_w   [3];
  logic [2:0] hr1_w   [3];
  logic       hclk_w  [3];
  logic       lat_w   [3];
  logic       oen_w   [3];
  logic       fs_w    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned ON = (g == 0) ? 40 : (g == 1) ? 0 : 128;
    assign r0_w[g] = col_w[g][2:0];
    assign r1_w[g] = ~col_w[g][2:0];
    hub75_scan_driver #(.COLUMNS(64), .ROWS_HALF(16), .ON_CYCLES(ON)) u_dut (
      .clk(clk), .rst(rst), .en(en),
      .rgb0_in(r0_w[g]), .rgb1_in(r1_w[g]),
      .column(col_w[g]), .addr(addr_w[g]),
      .hub_rgb0(hr0_w[g]), .hub_rgb1(hr1_w[g]),
      .hub_clk(hclk_w[g]), .hub_lat(lat_w[g]), .hub_oe_n(oen_w[g]),
      .hub_addr(haddr_w[g]), .frame_start(fs_w[g])
    );
  end

  int n_chk = 0, n_fail = 0;
  int cyc_n, low40, low0, low128, viol;
  bit prev_clk, prev_lat;
  logic [2:0] cap0[$], cap1[$];
  logic [3:0] lat_haddr[$], fs_haddr[$];
  int lat_cyc[$], fs_cyc[$], row40[$], row0[$], row128[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    cyc_n = 0; low40 = 0; low0 = 0; low128 = 0;
    prev_clk = hclk_w[0]; prev_lat = lat_w[0];
    cap0.delete(); cap1.delete(); lat_haddr.delete(); fs_haddr.delete();
    lat_cyc.delete(); fs_cyc.delete(); row40.delete(); row0.delete(); row128.delete();
  endtask

  // One clock, sampled 1 time unit after the edge, feeding the trackers.
  task automatic step();
    @(posedge clk); #1;
    cyc_n++;
    if (hclk_w[0] && !prev_clk) begin
      cap0.push_back(hr0_w[0]);
      cap1.push_back(hr1_w[0]);
    end
    if (!oen_w[0]) low40++;
    if (!oen_w[1]) low0++;
    if (!oen_w[2]) low128++;
    if (prev_lat) lat_haddr.push_back(haddr_w[0]);
    if (lat_w[0]) begin
      lat_cyc.push_back(cyc_n);
      row40.push_back(low40); row0.push_back(low0); row128.push_back(low128);
      low40 = 0; low0 = 0; low128 = 0;
      if (hclk_w[0] || !oen_w[0] || hclk_w[2] || !oen_w[2]) viol++;
    end
    if (fs_w[0]) begin
      fs_cyc.push_back(cyc_n);
      fs_haddr.push_back(haddr_w[0]);
    end
    prev_clk = hclk_w[0];
    prev_lat = lat_w[0];
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " oe_n"},  32'(oen_w[0]), 1);
    chk({tag, " clk"},   32'(hclk_w[0]), 0);
    chk({tag, " lat"},   32'(lat_w[0]), 0);
    chk({tag, " rgb0"},  32'(hr0_w[0]), 0);
    chk({tag, " rgb1"},  32'(hr1_w[0]), 0);
    chk({tag, " haddr"}, 32'(haddr_w[0]), 0);
    chk({tag, " addr"},  32'(addr_w[0]), 0);
    chk({tag, " fs"},    32'(fs_w[0]), 0);
    chk({tag, " col"},   32'(col_w[0]), 0);
  endtask

  initial begin
    int n;
    viol = 0;
    clear();
    repeat (3) step();
    chk_reset("reset");

    // Scan two full frames from reset.
    rst = 1'b0; en = 1'b1;
    clear();
    while (cyc_n < 4300) step();
    chk("cap count", 32'(cap0.size()), 2101);
    if (cap0.size() >= 64) begin
      for (int k = 0; k < 64; k++) begin
        chk($sformatf("pix%0d rgb0", k), 32'(cap0[k]), 32'(k & 7));
        chk($sformatf("pix%0d rgb1", k), 32'(cap1[k]), 32'(~k & 7));
      end
    end
    n = 0;
    foreach (lat_cyc[i]) if (lat_cyc[i] <= 131) n++;
    chk("lat pulses row0", n, 1);
    chk("lat count", 32'(lat_cyc.size()), 32);
    if (lat_cyc.size() >= 2) begin
      chk("lat first", lat_cyc[0], 130);
      chk("lat period", lat_cyc[1] - lat_cyc[0], 131);
    end
    chk("fs count", 32'(fs_cyc.size()), 3);
    if (fs_cyc.size() == 3) begin
      chk("fs first", fs_cyc[0], 1);
      chk("fs period1", fs_cyc[1] - fs_cyc[0], 2096);
      chk("fs period2", fs_cyc[2] - fs_cyc[1], 2096);
      chk("fs haddr0", 32'(fs_haddr[0]), 0);
      chk("fs haddr1", 32'(fs_haddr[1]), 15);
      chk("fs haddr2", 32'(fs_haddr[2]), 15);
    end
    chk("haddr count", 32'(lat_haddr.size()), 32);
    foreach (lat_haddr[i]) chk($sformatf("haddr lat%0d", i), 32'(lat_haddr[i]), 32'(i % 16));
    foreach (row40[i]) begin
      chk($sformatf("oe40 row%0d", i),  row40[i],  (i == 0) ? 0 : 40);
      chk($sformatf("oe0 row%0d", i),   row0[i],   0);
      chk($sformatf("oe128 row%0d", i), row128[i], (i == 0) ? 0 : 128);
    end

    // Drop en at s=50 of row 3; the row must still finish.
    rst = 1'b1; en = 1'b0;
    repeat (2) step();
    rst = 1'b0; en = 1'b1;
    clear();
    while (cyc_n < 444) step();
    chk("row3 col@s50", 32'(col_w[0]), 25);
    en = 1'b0;
    while (cyc_n < 560) step();
    chk("en-drop lat count", 32'(lat_cyc.size()), 4);
    if (lat_cyc.size() >= 4) chk("row3 lat cyc", lat_cyc[3], 523);
    if (lat_haddr.size() >= 4) chk("row3 haddr", 32'(lat_haddr[3]), 3);
    chk("idle caps", 32'(cap0.size()), 256);
    chk("idle oe_n", 32'(oen_w[0]), 1);
    chk("idle clk", 32'(hclk_w[0]), 0);
    chk("idle addr", 32'(addr_w[0]), 4);
    chk("idle low40", low40, 0);
    chk("idle low128", low128, 0);

    // Re-enable: resumes at row 4, lit.
    en = 1'b1;
    clear();
    step();
    chk("resume addr", 32'(addr_w[0]), 4);
    chk("resume col", 32'(col_w[0]), 0);
    chk("resume fs", 32'(fs_w[0]), 0);
    while (cyc_n < 131) step();
    chk("resume lat count", 32'(lat_cyc.size()), 1);
    if (row40.size() >= 1) begin
      chk("resume lat cyc", lat_cyc[0], 130);
      chk("resume oe40", row40[0], 40);
      chk("resume oe128", row128[0], 128);
    end
    if (lat_haddr.size() >= 1) chk("resume haddr", 32'(lat_haddr[0]), 4);

    // One-cycle reset at s=77 of row 5.
    while (cyc_n < 209) step();
    chk("s77 col", 32'(col_w[0]), 38);
    chk("s77 rgb0", 32'(hr0_w[0]), 6);
    chk("s77 rgb1", 32'(hr1_w[0]), 1);
    rst = 1'b1;
    step();
    chk_reset("midrow rst");
    rst = 1'b0;
    clear();
    step();
    chk("post-rst fs", 32'(fs_w[0]), 1);
    chk("post-rst addr", 32'(addr_w[0]), 0);
    while (cyc_n < 131) step();
    chk("post-rst lat count", 32'(lat_cyc.size()), 1);
    if (row40.size() >= 1) begin
      chk("post-rst dark40", row40[0], 0);
      chk("post-rst dark128", row128[0], 0);
    end
    if (lat_haddr.size() >= 1) chk("post-rst haddr", 32'(lat_haddr[0]), 0);
    chk("lat vs clk/oe", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hub75_scan_driver.md
# hub75_scan_driver

Scan controller for the 64x32 HUB75 panel: it walks the framebuffer's (ADDR, column) read interface, shifts each row pair out on RGB0/RGB1 with a generated shift clock, then latches the data and manages output enable. It sits between the framebuffer, which answers a column/ADDR index combinationally, and the panel connector pins, so it is the initiator for the framebuffer's read port. One row pair takes 2*COLUMNS+3 cycles, and a frame is ROWS_HALF row pairs.

## Interface
- COLUMNS, 64: pixels per row; a power of two, matching the width of `column`.
- ROWS_HALF, 16: row pairs per frame; a power of two, matching the width of `addr`.
- ON_CYCLES, 128: SHIFT cycles per row with the panel lit; legal range 0..2*COLUMNS (brightness).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; sampled only in IDLE and UNBLANK.
- rgb0_in  in  3  framebuffer RGB0, valid in the same cycle as `column`/`addr`.
- rgb1_in  in  3  framebuffer RGB1.
- column  out  6  framebuffer column index; combinational from the shift counter.
- addr  out  4  framebuffer row index (the row being shifted); registered.
- hub_rgb0  out  3  panel upper-half data; registered.
- hub_rgb1  out  3  panel lower-half data; registered.
- hub_clk  out  1  panel shift clock; the panel samples on the rising edge.
- hub_lat  out  1  panel latch strobe, active high.
- hub_oe_n  out  1  panel output enable, active low.
- hub_addr  out  4  panel row select (the displayed row); registered.
- frame_start  out  1  one-cycle pulse on the first SHIFT cycle of row 0.

## Operation
- Internal state:
  - shift counter `s`, 0..2*COLUMNS-1; `column = s[6:1]`.
  - row counter driving `addr`.
  - `shown` flag, cleared by rst and set at the first LATCH.
- State machine: IDLE, SHIFT, BLANK, LATCH, UNBLANK.
- IDLE: hub_oe_n=1 and hub_clk=0; goes to SHIFT when en=1, with `s` set to 0.
- SHIFT (2*COLUMNS cycles):
  - At the end of an even-`s` cycle: hub_rgb0/1 <= rgb0/1_in and hub_clk <= 0.
  - At the end of an odd-`s` cycle: hub_clk <= 1.
  - After s=2*COLUMNS-1, the next state is BLANK.
- BLANK (1 cycle): hub_oe_n=1; hub_clk=1 shows the final (64th) rising edge.
- LATCH (1 cycle): hub_lat=1, hub_clk=0, hub_oe_n=1, hub_addr <= addr.
- UNBLANK (1 cycle): hub_lat=0; `addr` <= `addr`+1, wrapping from ROWS_HALF-1 to 0.
  - If en=1: next state SHIFT with s=0.
  - If en=0: next state IDLE.
- hub_oe_n during SHIFT: low exactly when `shown`=1 and s < ON_CYCLES; high otherwise.
  - ON_CYCLES=0 keeps the panel dark at all times.
  - The first row after reset is always dark because nothing has been latched yet.
- frame_start: 1 during the s=0 SHIFT cycle when addr=0; 0 otherwise.
- Deasserting en mid-row has no effect until UNBLANK. The current row always completes shift and latch.

## Timing
- Reset values, taking effect on the clock edge with rst=1:
  - state IDLE, s=0, addr=0, hub_addr=0, shown=0.
  - hub_rgb0=hub_rgb1=0, hub_clk=0, hub_lat=0, hub_oe_n=1, frame_start=0.
- rst overrides all other behaviour in any state, including mid-SHIFT. Outputs return to their reset values one cycle after rst is sampled.
- Framebuffer latency is zero. `column` changes on the clock edge that ends each odd-`s` cycle.
- Pixel k:
  - Appears on hub_rgb* in the cycle after s=2k.
  - Is sampled by the panel on the hub_clk rise in the cycle after s=2k+1.
  - This gives one cycle of setup and one cycle of hold.
- Row period is 2*COLUMNS+3 = 131 cycles. Frame period is 16*131 = 2096 cycles with en held at 1.
- hub_lat is never high while hub_clk=1 or hub_oe_n=0. hub_addr changes only in LATCH, with oe_n=1.

## Test plan
- Reset then en=1, with a framebuffer model returning {column[2:0]} on RGB0 and ~{column[2:0]} on RGB1:
  - The bench captures 64 values on each hub_clk rise; value k must equal k[2:0] and ~k[2:0].
  - hub_lat must pulse exactly once, 130 cycles after leaving IDLE.
- Run two frames with en=1:
  - frame_start pulses every 2096 cycles.
  - hub_addr takes values 0,1,...,15,0 at each LATCH.
  - addr leads hub_addr by one row.
- Brightness: with ON_CYCLES=40, oe_n must be low for exactly 40 cycles per row from row 1 onward.
  - Row 0 of the first frame must show 0 cycles low.
  - ON_CYCLES=0 must give 0 cycles low; ON_CYCLES=128 must give 128 cycles low.
- Drop en to 0 at s=50 of row 3:
  - Row 3 still completes shift and latch, then the block goes to IDLE with hub_oe_n=1.
  - After re-enabling, shifting resumes with addr=4.
- Assert rst for one cycle at s=77:
  - All outputs take their reset values on the next cycle.
  - With en=1, the next SHIFT starts at addr=0 and that row is dark.
